alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Control-side master of the 4-bit ALU (A, B, opcode in; result, zeroFlag, overflowFlag out).
- Accepts one instruction at a time over a valid/ready handshake. Reads operands from a 4-entry register file, drives the ALU, then writes the result back and latches the flags.
- Sits between instruction source and ALU. It is the block that produces the stimulus the ALU consumes and consumes the ALU response.

Parameters:
- WIDTH, 4, data width of registers and ALU operands/result
- NREGS, 4, register-file depth (index width = 2; fixed for NREGS=4)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- instrValid  input  1  instruction offered
- instrReady  output  1  sequencer can accept instruction
- instr  input  12  instruction word (format below)
- aluA  output  WIDTH  operand A to ALU
- aluB  output  WIDTH  operand B to ALU (for shift op: B[3]=direction, 1=left; B[2:0]=count)
- aluOpcode  output  3  opcode to ALU
- aluResult  input  WIDTH  ALU result (combinational from aluA/aluB/aluOpcode)
- aluZero  input  1  ALU zeroFlag
- aluOverflow  input  1  ALU overflowFlag
- doneValid  output  1  one-cycle pulse, instruction retired
- doneData  output  WIDTH  value written to rd by retired instruction
- zeroFlag  output  1  latched zero flag
- overflowFlag  output  1  latched overflow flag
- dbgAddr  input  2  register-file read index
- dbgData  output  WIDTH  combinational read of reg[dbgAddr]

Behaviour:
- Instruction format, instr[11] = isLoad:
  - isLoad=1 (load immediate): rd = instr[7:6], imm = instr[3:0].
  - isLoad=0 (ALU op): opcode = instr[10:8], rd = instr[7:6], rsA = instr[5:4], rsB = instr[3:2]; instr[1:0] ignored.
- Reset (async, immediate), all outputs and state zero:
  - state=IDLE; all registers = 0.
  - aluA/aluB/aluOpcode = 0; zeroFlag = overflowFlag = 0; doneValid = 0; doneData = 0.
  - instrReady = 1 once reset deasserts.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: instrReady = 1. On instrValid at the clock edge, the instruction is captured and the state goes to EXEC. An ALU op also registers aluA = reg[rsA], aluB = reg[rsB], aluOpcode = opcode at that same edge.
  - EXEC: instrReady = 0; ALU inputs are stable for the whole cycle. At the end-of-cycle edge:
    - ALU op: reg[rd] <= aluResult; zeroFlag <= aluZero; overflowFlag <= aluOverflow; doneData <= aluResult.
    - Load: reg[rd] <= imm; doneData <= imm; flags unchanged; ALU outputs unchanged.
    - Then go to DONE.
  - DONE: doneValid = 1 for exactly this cycle; instrReady = 0. Then go to IDLE.
- Throughput and latency:
  - One instruction per 3 cycles.
  - doneValid is asserted 2 cycles after the accepting edge.
  - The register write is visible on dbgData from the DONE cycle onward.
- aluA/aluB/aluOpcode hold their last values outside EXEC; they are not cleared.
- rsA/rsB equal to rd: operands are read before the writeback, so old values are used.
- Back-to-back dependent instructions: the second instruction reads the value written by the first. This is guaranteed because the write completes before IDLE.
- dbgAddr equal to a register being written at the same edge: dbgData shows the old value before the edge and the new value after it.
- instrValid while instrReady = 0: ignored. The source must hold instr until accepted; there is no buffering.
- Opcodes are passed to the ALU unmodified. The sequencer does not interpret them.
- Arithmetic is done entirely in the ALU. Results wrap at WIDTH and no carry is stored.
- Reset mid-EXEC or mid-DONE:
  - The instruction is dropped; no doneValid pulse and no register write.
  - The register file is cleared.

Test Plan:
- After reset: instrReady=1, doneValid=0, flags=0, dbgData=0 for all four addresses. Assert reset during EXEC -> no doneValid, reg[rd] stays 0.
- Load R1=1010 (instr=12'h84A), then load R2=1001 (instr=12'h889):
  - doneValid 2 cycles after each accept.
  - doneData=1010, then 1001.
  - dbgAddr=1 -> 1010, dbgAddr=2 -> 1001.
- Shift op: opcode=011, rd=R3, rsA=R1, rsB=R2 (instr=12'h3D8), driving the real ALU:
  - aluA=1010, aluB=1001 during EXEC.
  - R3=0100, doneData=0100 (left shift by 1).
  - zeroFlag=0.
- Load R2=0010, then the same shift op with rd=R3 -> R3=0010 (right shift by 2).
  - Then load R2=0100 (right, count 4) and repeat -> R3=0000, zeroFlag=1.
- Dependency and alias check: ALU op with rd=rsA=R1, back-to-back with a second op reading R1.
  - The first op uses the old R1.
  - The second op sees the updated R1.
- Handshake: hold instrValid=1 continuously with a changing instr each cycle -> exactly one accept per 3 cycles, instrReady low in EXEC/DONE, ignored words never executed.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Signal bundle between the ALU sequencer and its surroundings: instruction handshake,
// ALU stimulus and response, retire/flag outputs and the register-file debug port.
interface alu_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             instrValid;
  logic             instrReady;
  logic [11:0]      instr;
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;
  logic [2:0]       aluOpcode;
  logic [WIDTH-1:0] aluResult;
  logic             aluZero;
  logic             aluOverflow;
  logic             doneValid;
  logic [WIDTH-1:0] doneData;
  logic             zeroFlag;
  logic             overflowFlag;
  logic [1:0]       dbgAddr;
  logic [WIDTH-1:0] dbgData;

  modport master (
    input  instrValid, instr, aluResult, aluZero, aluOverflow, dbgAddr,
    output instrReady, aluA, aluB, aluOpcode, doneValid, doneData,
           zeroFlag, overflowFlag, dbgData
  );

  modport slave (
    output instrValid, instr, aluResult, aluZero, aluOverflow, dbgAddr,
    input  instrReady, aluA, aluB, aluOpcode, doneValid, doneData,
           zeroFlag, overflowFlag, dbgData
  );
endinterface

// File: rtl/alu_sequencer.sv
// Runs one instruction every 3 cycles (accept, EXEC, DONE); doneValid 2 cycles after accept.
// instrReady is high only in IDLE; offers made while it is low are ignored, nothing is buffered.
module alu_sequencer #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             reset,
  alu_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_is_load;
  logic [1:0]       r_rd;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_opcode;
  logic [WIDTH-1:0] r_done_data;
  logic             r_zero_flag;
  logic             r_overflow_flag;

  logic             w_accept;
  logic             w_instr_ready;
  logic             w_done_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:  w_next_state = bus.instrValid ? S_EXEC : S_IDLE;
      S_EXEC:  w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Ready is forced low while reset is held so every output reads zero during reset.
  always_comb begin
    w_instr_ready = 1'b0;
    w_done_valid  = 1'b0;
    case (r_state)
      S_IDLE:  w_instr_ready = ~reset;
      S_DONE:  w_done_valid  = 1'b1;
      default: ;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && bus.instrValid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_is_load       <= 1'b0;
      r_rd            <= '0;
      r_imm           <= '0;
      r_alu_a         <= '0;
      r_alu_b         <= '0;
      r_alu_opcode    <= '0;
      r_done_data     <= '0;
      r_zero_flag     <= 1'b0;
      r_overflow_flag <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_load <= bus.instr[11];
        r_rd      <= bus.instr[7:6];
        r_imm     <= WIDTH'(bus.instr[3:0]);
        // Operands are sampled here, before any writeback, so rs==rd reads the old value.
        if (!bus.instr[11]) begin
          r_alu_a      <= r_regs[bus.instr[5:4]];
          r_alu_b      <= r_regs[bus.instr[3:2]];
          r_alu_opcode <= bus.instr[10:8];
        end
      end
      if (r_state == S_EXEC) begin
        if (r_is_load) begin
          r_regs[r_rd] <= r_imm;
          r_done_data  <= r_imm;
        end else begin
          r_regs[r_rd]    <= bus.aluResult;
          r_done_data     <= bus.aluResult;
          r_zero_flag     <= bus.aluZero;
          r_overflow_flag <= bus.aluOverflow;
        end
      end
    end
  end

  assign bus.instrReady   = w_instr_ready;
  assign bus.doneValid    = w_done_valid;
  assign bus.aluA         = r_alu_a;
  assign bus.aluB         = r_alu_b;
  assign bus.aluOpcode    = r_alu_opcode;
  assign bus.doneData     = r_done_data;
  assign bus.zeroFlag     = r_zero_flag;
  assign bus.overflowFlag = r_overflow_flag;
  assign bus.dbgData      = r_regs[bus.dbgAddr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit ALU closing the loop.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_miss = 0;

  alu_sequencer_if #(.WIDTH(4)) bus();

  alu_sequencer #(.WIDTH(4), .NREGS(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ALU: 000 add, 001 sub, 010 and, 011 shift (B[3]=1 left, B[2:0]=count), others or.
  always_comb begin
    logic [3:0] r;
    logic       ov;
    ov = 1'b0;
    case (bus.aluOpcode)
      3'b000: begin
        r  = bus.aluA + bus.aluB;
        ov = (bus.aluA[3] == bus.aluB[3]) && (r[3] != bus.aluA[3]);
      end
      3'b001: begin
        r  = bus.aluA - bus.aluB;
        ov = (bus.aluA[3] != bus.aluB[3]) && (r[3] != bus.aluA[3]);
      end
      3'b010:  r = bus.aluA & bus.aluB;
      3'b011:  r = bus.aluB[3] ? (bus.aluA << bus.aluB[2:0]) : (bus.aluA >> bus.aluB[2:0]);
      default: r = bus.aluA | bus.aluB;
    endcase
    bus.aluResult   = r;
    bus.aluZero     = (r == 4'd0);
    bus.aluOverflow = ov;
  end

  task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers instr and returns at the EXEC-cycle sample point.
  task automatic accept(input logic [11:0] word);
    int waited;
    waited = 0;
    bus.instrValid = 1'b1;
    bus.instr      = word;
    while (!bus.instrReady && waited < 10) begin
      tick();
      waited++;
    end
    chk_eq("accept_ready", bus.instrReady, 1'b1);
    tick();
    bus.instrValid = 1'b0;
    chk_eq("exec_ready", bus.instrReady, 1'b0);
    chk_eq("exec_done", bus.doneValid, 1'b0);
  endtask

  // From EXEC: checks the DONE cycle (pulse, data, writeback) and returns in IDLE.
  task automatic finish(input logic [1:0] rd, input logic [3:0] exp);
    bus.dbgAddr = rd;
    tick();
    chk_eq("done_valid", bus.doneValid, 1'b1);
    chk_eq("done_data", bus.doneData, exp);
    chk_eq("done_ready", bus.instrReady, 1'b0);
    chk_eq("wb_visible", bus.dbgData, exp);
    tick();
    chk_eq("idle_done", bus.doneValid, 1'b0);
    chk_eq("idle_ready", bus.instrReady, 1'b1);
  endtask

  task automatic dbg(input string tag, input logic [1:0] a, input logic [3:0] exp);
    bus.dbgAddr = a;
    #1;
    chk_eq(tag, bus.dbgData, exp);
  endtask

  logic [8:0]  hs_rdy = 9'b001001001;   // bit k = expected instrReady at cycle k
  logic [8:0]  hs_dv  = 9'b100100100;
  logic [3:0]  hs_dd [9] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd4, 4'd4, 4'd4, 4'd7};

  initial begin
    bus.instrValid = 1'b0;
    bus.instr      = '0;
    bus.dbgAddr    = '0;
    #2;
    chk_eq("rst_ready_held", bus.instrReady, 1'b0);
    #10;
    reset = 1'b0;
    #1;
    chk_eq("rst_ready", bus.instrReady, 1'b1);
    chk_eq("rst_done", bus.doneValid, 1'b0);
    chk_eq("rst_zero", bus.zeroFlag, 1'b0);
    chk_eq("rst_ovf", bus.overflowFlag, 1'b0);
    chk_eq("rst_alu", {bus.aluA, bus.aluB, 1'b0, bus.aluOpcode}, 16'h0);
    chk_eq("rst_data", bus.doneData, 4'h0);
    for (int a = 0; a < 4; a++) dbg("rst_reg", 2'(a), 4'h0);
    tick();

    // Reset in the middle of EXEC drops the load of R1.
    accept(12'h84A);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk_eq("midrst_ready", bus.instrReady, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_eq("midrst_done", bus.doneValid, 1'b0);
    end
    dbg("midrst_r1", 2'd1, 4'h0);

    accept(12'h84A); finish(2'd1, 4'b1010);
    accept(12'h889); finish(2'd2, 4'b1001);
    dbg("ld_r1", 2'd1, 4'b1010);
    dbg("ld_r2", 2'd2, 4'b1001);

    accept(12'h3D8);
    chk_eq("sh1_a", bus.aluA, 4'b1010);
    chk_eq("sh1_b", bus.aluB, 4'b1001);
    chk_eq("sh1_op", bus.aluOpcode, 3'b011);
    finish(2'd3, 4'b0100);
    chk_eq("sh1_zero", bus.zeroFlag, 1'b0);

    accept(12'h882); finish(2'd2, 4'b0010);
    accept(12'h3D8); finish(2'd3, 4'b0010);
    chk_eq("sh2_zero", bus.zeroFlag, 1'b0);
    accept(12'h884); finish(2'd2, 4'b0100);
    accept(12'h3D8); finish(2'd3, 4'b0000);
    chk_eq("sh3_zero", bus.zeroFlag, 1'b1);

    // R1 = R1 + R2 (alias), then R0 = R1 + R2 must see the new R1.
    accept(12'h058);
    chk_eq("dep1_a_old", bus.aluA, 4'b1010);
    chk_eq("dep1_b", bus.aluB, 4'b0100);
    finish(2'd1, 4'b1110);
    accept(12'h018);
    chk_eq("dep2_a_new", bus.aluA, 4'b1110);
    finish(2'd0, 4'b0010);
    chk_eq("dep2_ovf", bus.overflowFlag, 1'b0);
    chk_eq("dep2_zero", bus.zeroFlag, 1'b0);
    accept(12'h028); finish(2'd0, 4'b1000);
    chk_eq("add_ovf", bus.overflowFlag, 1'b1);
    chk_eq("alu_hold_a", bus.aluA, 4'b0100);

    // Valid held high with a new load of R3 every cycle; only every third word retires.
    bus.dbgAddr    = 2'd3;
    bus.instrValid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus.instr = 12'h8C0 | 12'(k + 1);
      #1;
      chk_eq("hs_ready", bus.instrReady, hs_rdy[k]);
      chk_eq("hs_done", bus.doneValid, hs_dv[k]);
      if (hs_dv[k]) chk_eq("hs_data", bus.doneData, hs_dd[k]);
      tick();
    end
    bus.instrValid = 1'b0;
    dbg("hs_r3", 2'd3, 4'd7);
    chk_eq("hs_flags_kept", {bus.zeroFlag, bus.overflowFlag}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
